// File: rtl/mac_rx_frame_gate_if.sv
// ============================================================================
//  Module      : mac_rx_frame_gate_if
//  Description : AXI-Stream bundle used on both sides of the RX frame gate.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mac_rx_frame_gate_if #(
    parameter int N_SYMBOLS = 4,
    parameter int W_SYMBOL  = 8
);
    logic                          tvalid;
    logic                          tready;
    logic [N_SYMBOLS-1:0]          tkeep;
    logic [N_SYMBOLS*W_SYMBOL-1:0] tdata;
    logic                          tlast;
    logic                          tuser;

    modport master (output tvalid, tkeep, tdata, tlast, tuser, input tready);
    modport slave  (input tvalid, tkeep, tdata, tlast, tuser, output tready);
endinterface

`default_nettype wire

// File: rtl/mac_rx_frame_gate.sv
// ============================================================================
//  Module      : mac_rx_frame_gate
//  Description : Store-and-forward RX frame gate; only good frames are released.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_rx_frame_gate #(
    parameter int DEPTH_LOG2 = 9,
    parameter int MAX_BEATS  = 381,
    parameter int N_SYMBOLS  = 4,
    parameter int W_SYMBOL   = 8
) (
    input  wire logic              i_clk,
    input  wire logic              i_reset,
    input  wire logic              i_clk_en,
    mac_rx_frame_gate_if.slave     s_axis,
    mac_rx_frame_gate_if.master    m_axis,
    output logic [15:0]            o_frames_ok,
    output logic [15:0]            o_frames_drop,
    output logic [15:0]            o_overflow_drop
);
    localparam int c_W_DATA = N_SYMBOLS * W_SYMBOL;
    localparam int c_W_WORD = 1 + N_SYMBOLS + c_W_DATA;
    localparam int c_DEPTH  = 2 ** DEPTH_LOG2;
    localparam int c_W_PTR  = DEPTH_LOG2 + 1;
    localparam int c_W_CNT  = $clog2(MAX_BEATS + 1);
    localparam logic [c_W_PTR-1:0] c_FULL = c_W_PTR'(c_DEPTH);
    localparam logic [c_W_CNT-1:0] c_MAX  = c_W_CNT'(MAX_BEATS);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RECV    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    logic [1:0]           r_state, w_state_next;
    logic [c_W_PTR-1:0]   r_wr_ptr, r_wr_commit, r_rd_ptr, w_used;
    logic                 r_h_vld;
    logic [N_SYMBOLS-1:0] r_h_keep;
    logic [c_W_DATA-1:0]  r_h_data;
    logic [c_W_CNT-1:0]   r_beat_cnt;
    logic [c_W_WORD-1:0]  r_mem [c_DEPTH];

    logic                 r_out_vld, r_out_last;
    logic [N_SYMBOLS-1:0] r_out_keep;
    logic [c_W_DATA-1:0]  r_out_data;

    logic w_acc, w_err, w_eof, w_pay, w_full, w_oversize, w_out_load;
    logic w_wr_en, w_wr_last, w_commit, w_rollback, w_h_load, w_frame_end;
    logic w_inc_ok, w_inc_drop, w_inc_ovf;

    assign w_acc      = s_axis.tvalid & i_clk_en;
    assign w_err      = w_acc & ~s_axis.tuser;
    assign w_eof      = w_acc & s_axis.tuser & s_axis.tlast;
    assign w_pay      = w_acc & s_axis.tuser & ~s_axis.tlast & (|s_axis.tkeep);
    assign w_used     = r_wr_ptr - r_rd_ptr;
    assign w_full     = (w_used == c_FULL);
    assign w_oversize = (r_beat_cnt == c_MAX);

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_err || w_eof) begin
            w_state_next = ST_IDLE;
        end else if (w_pay && r_state != ST_DISCARD) begin
            if (w_oversize || (r_h_vld && w_full)) w_state_next = ST_DISCARD;
            else                                   w_state_next = ST_RECV;
        end
    end

    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_last   = 1'b0;
        w_commit    = 1'b0;
        w_rollback  = 1'b0;
        w_h_load    = 1'b0;
        w_frame_end = 1'b0;
        w_inc_ok    = 1'b0;
        w_inc_drop  = 1'b0;
        w_inc_ovf   = 1'b0;
        if (w_err) begin
            w_rollback = 1'b1;
            w_inc_drop = (r_state != ST_DISCARD);
        end else if (w_eof) begin
            w_frame_end = 1'b1;
            if (r_state == ST_RECV) begin
                // The closing word itself may not fit; treat that as overflow.
                if (w_full) begin
                    w_rollback = 1'b1;
                    w_inc_ovf  = 1'b1;
                    w_inc_drop = 1'b1;
                end else begin
                    w_wr_en   = 1'b1;
                    w_wr_last = 1'b1;
                    w_commit  = 1'b1;
                    w_inc_ok  = 1'b1;
                end
            end else if (r_state == ST_DISCARD) begin
                w_inc_drop = 1'b1;
            end
        end else if (w_pay && r_state != ST_DISCARD) begin
            if (w_oversize) begin
                w_rollback = 1'b1;
            end else if (r_h_vld && w_full) begin
                w_rollback = 1'b1;
                w_inc_ovf  = 1'b1;
            end else begin
                w_wr_en  = r_h_vld;
                w_h_load = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr    <= '0;
            r_wr_commit <= '0;
            r_h_vld     <= 1'b0;
            r_h_keep    <= '0;
            r_h_data    <= '0;
            r_beat_cnt  <= '0;
        end else begin
            if (w_rollback)   r_wr_ptr <= r_wr_commit;
            else if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_commit)     r_wr_commit <= r_wr_ptr + 1'b1;
            if (w_h_load) begin
                r_h_vld    <= 1'b1;
                r_h_keep   <= s_axis.tkeep;
                r_h_data   <= s_axis.tdata;
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end else if (w_rollback || w_frame_end) begin
                r_h_vld    <= 1'b0;
                r_beat_cnt <= '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= {w_wr_last, r_h_keep, r_h_data};
    end

    // Reads stop at wr_commit, so a rollback never touches a word in flight.
    assign w_out_load = (~r_out_vld | m_axis.tready) & (r_rd_ptr != r_wr_commit);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_ptr   <= '0;
            r_out_vld  <= 1'b0;
            r_out_last <= 1'b0;
            r_out_keep <= '0;
            r_out_data <= '0;
        end else if (w_out_load) begin
            {r_out_last, r_out_keep, r_out_data} <= r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
            r_out_vld <= 1'b1;
            r_rd_ptr  <= r_rd_ptr + 1'b1;
        end else if (m_axis.tready) begin
            r_out_vld <= 1'b0;
        end
    end

    function automatic logic [15:0] f_sat_inc(input logic [15:0] v, input logic inc);
        return (inc && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_frames_ok     <= '0;
            o_frames_drop   <= '0;
            o_overflow_drop <= '0;
        end else begin
            o_frames_ok     <= f_sat_inc(o_frames_ok, w_inc_ok);
            o_frames_drop   <= f_sat_inc(o_frames_drop, w_inc_drop);
            o_overflow_drop <= f_sat_inc(o_overflow_drop, w_inc_ovf);
        end
    end

    assign m_axis.tvalid = r_out_vld;
    assign m_axis.tlast  = r_out_last;
    assign m_axis.tkeep  = r_out_keep;
    assign m_axis.tdata  = r_out_data;
    assign m_axis.tuser  = 1'b1;
    assign s_axis.tready = 1'b1;
endmodule

`default_nettype wire

// File: tb/tb_mac_rx_frame_gate.sv
// ============================================================================
//  Module      : tb_mac_rx_frame_gate
//  Description : Directed self-checking bench for mac_rx_frame_gate.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_rx_frame_gate;
    localparam int c_DEPTH_LOG2 = 4;
    localparam int c_MAX_BEATS  = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_en = 1'b1;
    logic [15:0] frames_ok, frames_drop, overflow_drop;

    always #5 clk = ~clk;

    mac_rx_frame_gate_if #(.N_SYMBOLS(4), .W_SYMBOL(8)) s_if ();
    mac_rx_frame_gate_if #(.N_SYMBOLS(4), .W_SYMBOL(8)) m_if ();

    mac_rx_frame_gate #(
        .DEPTH_LOG2 (c_DEPTH_LOG2),
        .MAX_BEATS  (c_MAX_BEATS),
        .N_SYMBOLS  (4),
        .W_SYMBOL   (8)
    ) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_clk_en        (clk_en),
        .s_axis          (s_if),
        .m_axis          (m_if),
        .o_frames_ok     (frames_ok),
        .o_frames_drop   (frames_drop),
        .o_overflow_drop (overflow_drop)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [32:0] q[$];
    logic        mon_stall = 1'b0;
    logic [36:0] mon_prev = '0;

    // Output collector plus hold-stable check during stalls.
    always @(negedge clk) begin
        if (mon_stall) begin
            n_cmp++;
            assert ({m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tdata} === {1'b1, mon_prev})
            else begin
                n_err++;
                $error("FAIL hold_stable: observed %h expected %h",
                       {m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tdata}, {1'b1, mon_prev});
            end
        end
        if (m_if.tvalid && m_if.tready) q.push_back({m_if.tlast, m_if.tdata});
        mon_stall = m_if.tvalid & ~m_if.tready & ~rst;
        mon_prev  = {m_if.tlast, m_if.tkeep, m_if.tdata};
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l,
                        input logic u, input logic en);
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tkeep  = k;
        s_if.tlast  = l;
        s_if.tuser  = u;
        clk_en      = en;
        @(posedge clk); #1;
        s_if.tvalid = 1'b0;
        clk_en      = 1'b1;
    endtask

    task automatic pay(input logic [31:0] d);
        send(d, 4'hF, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic eof_good();
        send(32'h0, 4'h0, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_if.tvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
    endtask

    task automatic wait_q(input int n, input int budget, input string tag);
        int k = 0;
        while (q.size() < n && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_count"}, 64'(q.size()), 64'(n));
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] d, input logic l);
        logic [32:0] e;
        if (q.size() > 0) e = q.pop_front();
        else              e = 'x;
        chk(tag, 64'(e), 64'({l, d}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
        m_if.tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_tvalid", 64'(m_if.tvalid), 64'd0);
        chk("rst_tlast",  64'(m_if.tlast),  64'd0);
        chk("rst_tdata",  64'(m_if.tdata),  64'd0);
        chk("rst_tkeep",  64'(m_if.tkeep),  64'd0);
        chk("rst_cnts",   64'({frames_ok, frames_drop, overflow_drop}), 64'd0);

        // Good frame, with a clk_en-blocked beat and a tkeep=0 beat mixed in
        m_if.tready = 1'b1;
        pay(32'h11111111);
        send(32'hDEADDEAD, 4'hF, 1'b0, 1'b1, 1'b0);
        pay(32'h22222222);
        send(32'hBEEFBEEF, 4'h0, 1'b0, 1'b1, 1'b1);
        pay(32'h33333333);
        eof_good();
        chk("t1_tvalid_T1", 64'(m_if.tvalid), 64'd0);
        @(posedge clk); #1;
        chk("t1_tvalid_T2", 64'(m_if.tvalid), 64'd1);
        chk("t1_first_data", 64'(m_if.tdata), 64'h11111111);
        wait_q(3, 10, "t1");
        pop_chk("t1_b0", 32'h11111111, 1'b0);
        pop_chk("t1_b1", 32'h22222222, 1'b0);
        pop_chk("t1_b2", 32'h33333333, 1'b1);
        chk("t1_ok",   64'(frames_ok),   64'd1);
        chk("t1_drop", 64'(frames_drop), 64'd0);

        // Mid-frame abort followed by a good 2-beat frame
        do_reset();
        m_if.tready = 1'b1;
        for (int i = 0; i < 5; i++) pay(32'hA0 + 32'(i));
        send(32'h0, 4'hF, 1'b0, 1'b0, 1'b1);
        pay(32'hB0);
        pay(32'hB1);
        eof_good();
        wait_q(2, 10, "t2");
        pop_chk("t2_b0", 32'hB0, 1'b0);
        pop_chk("t2_b1", 32'hB1, 1'b1);
        chk("t2_drop", 64'(frames_drop), 64'd1);
        chk("t2_ok",   64'(frames_ok),   64'd1);

        // Bad CRC
        do_reset();
        m_if.tready = 1'b1;
        for (int i = 0; i < 4; i++) pay(32'hC0 + 32'(i));
        send(32'h0, 4'h0, 1'b1, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("t3_no_out", 64'(q.size()), 64'd0);
        chk("t3_tvalid", 64'(m_if.tvalid), 64'd0);
        chk("t3_drop",   64'(frames_drop), 64'd1);
        chk("t3_ok",     64'(frames_ok),   64'd0);
        chk("t3_wr_ptr", 64'(dut.r_wr_ptr), 64'd0);
        chk("t3_commit", 64'(dut.r_wr_commit), 64'd0);

        // Overflow with the output stalled
        do_reset();
        m_if.tready = 1'b0;
        for (int i = 0; i < 10; i++) pay(32'h400 + 32'(i));
        eof_good();
        for (int i = 0; i < 10; i++) pay(32'h500 + 32'(i));
        eof_good();
        chk("t4_ovf",  64'(overflow_drop), 64'd1);
        chk("t4_drop", 64'(frames_drop),   64'd1);
        chk("t4_ok",   64'(frames_ok),     64'd1);
        chk("t4_held", 64'({m_if.tvalid, m_if.tdata}), 64'({1'b1, 32'h400}));
        m_if.tready = 1'b1;
        wait_q(10, 30, "t4");
        for (int i = 0; i < 10; i++) pop_chk("t4_beat", 32'h400 + 32'(i), (i == 9));

        // Oversize (limit 10 beats): 11-beat frame dropped, 10-beat frame passes
        do_reset();
        m_if.tready = 1'b1;
        for (int i = 0; i < 11; i++) pay(32'h600 + 32'(i));
        eof_good();
        for (int i = 0; i < 10; i++) pay(32'h700 + 32'(i));
        eof_good();
        wait_q(10, 30, "t5");
        for (int i = 0; i < 10; i++) pop_chk("t5_beat", 32'h700 + 32'(i), (i == 9));
        chk("t5_drop", 64'(frames_drop),   64'd1);
        chk("t5_ovf",  64'(overflow_drop), 64'd0);
        chk("t5_ok",   64'(frames_ok),     64'd1);

        // Back-to-back frames under toggling backpressure, wrapping the RAM
        do_reset();
        m_if.tready = 1'b1;
        fork
            begin
                for (int f = 0; f < 20; f++) begin
                    for (int b = 0; b < 3; b++) pay(32'h80000000 | 32'(f << 8) | 32'(b));
                    eof_good();
                end
            end
            begin
                for (int c = 0; c < 120; c++) begin
                    m_if.tready = ((c % 4) != 1);
                    @(posedge clk); #1;
                end
            end
        join
        m_if.tready = 1'b1;
        wait_q(60, 60, "t6");
        for (int f = 0; f < 20; f++)
            for (int b = 0; b < 3; b++)
                pop_chk("t6_beat", 32'h80000000 | 32'(f << 8) | 32'(b), (b == 2));
        chk("t6_ok",  64'(frames_ok),     64'd20);
        chk("t6_ovf", 64'(overflow_drop), 64'd0);

        // Reset with a stored frame and a partial frame in flight
        do_reset();
        m_if.tready = 1'b0;
        pay(32'h900);
        pay(32'h901);
        eof_good();
        repeat (2) @(posedge clk);
        #1;
        chk("t7_pre_tvalid", 64'(m_if.tvalid), 64'd1);
        pay(32'h910);
        pay(32'h911);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t7_rst_tvalid", 64'(m_if.tvalid), 64'd0);
        m_if.tready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("t7_no_out", 64'(q.size()), 64'd0);
        chk("t7_ok",     64'(frames_ok), 64'd0);
        pay(32'h920);
        eof_good();
        wait_q(1, 10, "t7");
        pop_chk("t7_beat", 32'h920, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire
